// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: two-flop synchroniser, per-bit debounce and sticky edge flags
// for the raw GPIO pin bus. The clean value feeds the GPIO block's PORT_IN.
// Build option: define GPIO_FALL_EDGE_EN to also flag falling transitions of the clean value.
module gpio_in_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PORT_RAW,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] PORT_CLEAN,
  output logic [31:0]      FlagsOut,
  output logic             irq
);

  // Smallest width holding DEBOUNCE_CYCLES-1, never less than one bit.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_flag;
  logic [CntW-1:0]  r_cnt [WIDTH];

  logic [WIDTH-1:0] w_clean_d;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_flag_d;
  logic [CntW-1:0]  w_cnt_d [WIDTH];

  // Debounce next-state: count consecutive mismatches, follow sync2 once the count tops out.
  always_comb begin
    w_clean_d = r_clean;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_d[i] = '0;
      if (r_sync2[i] != r_clean[i]) begin
        if (r_cnt[i] == CntMax) begin
          w_clean_d[i] = r_sync2[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  // Flag next-state: a new edge on the clean value wins over a same-cycle clear.
  always_comb begin
`ifdef GPIO_FALL_EDGE_EN
    w_set = w_clean_d ^ r_clean;
`else
    w_set = w_clean_d & ~r_clean;
`endif
    w_flag_d = (r_flag & ~flag_clr) | w_set;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_clean <= '0;
      r_flag  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= PORT_RAW;
      r_sync2 <= r_sync1;
      r_clean <= w_clean_d;
      r_flag  <= w_flag_d;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  // Outputs straight from registers; flags zero-extended to a 32-bit word.
  always_comb begin
    PORT_CLEAN            = r_clean;
    FlagsOut              = '0;
    FlagsOut[WIDTH-1:0]   = r_flag;
    irq                   = |r_flag;
  end

endmodule
